// File: rtl/seq_pkg.sv
// Shared definitions for the serial sequence transmitter and detector blocks.
// Holds the FSM state encoding and the default preamble.
package seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_PAY  = 2'd2,
    ST_GAP  = 2'd3
  } seq_state_e;

  localparam int SEQ_PRE_LEN = 4;
  localparam logic [SEQ_PRE_LEN-1:0] SEQ_PREAMBLE = 4'b1010;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/seq_shift_out.sv
// Parallel-load, MSB-first shift register.
// The MSB is presented combinationally and the register shifts left on enable.
module seq_shift_out #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         msb
);

  logic [W-1:0] sr;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '0;
    end else if (load) begin
      sr <= din;
    end else if (shift) begin
      sr <= sr << 1;
    end
  end

  assign msb = sr[W-1];

endmodule

// File: rtl/sequence_tx.sv
// Serial frame transmitter: preamble, MSB-first payload, then a zero gap.
// The state always describes the bit currently on data_out.
module sequence_tx
  import seq_pkg::*;
#(
  parameter int                  DATA_W     = 8,
  parameter int                  PRE_LEN    = SEQ_PRE_LEN,
  parameter logic [PRE_LEN-1:0]  PREAMBLE   = SEQ_PREAMBLE,
  parameter int                  GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  input  logic              abort,
  output logic              data_out,
  output logic              busy,
  output logic              frame_done
);

  localparam int CW =
    $clog2(max3(PRE_LEN, DATA_W, GAP_CYCLES)) + 1;

  localparam logic [CW-1:0] PRE_LAST = CW'(PRE_LEN - 1);
  localparam logic [CW-1:0] PAY_LAST = CW'(DATA_W - 1);
  localparam logic [CW-1:0] PAY_PEN  = CW'(DATA_W - 2);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
  localparam bit            HAS_GAP  = (GAP_CYCLES != 0);
  localparam bit            ONE_BIT  = (DATA_W == 1);

  seq_state_e       state;
  logic [CW-1:0]    cnt;
  logic [PRE_LEN-1:0] pre_sr;
  logic             accept;
  logic             sr_shift;
  logic             sr_msb;
  logic             last_pay;

  assign accept   = (state == ST_IDLE) && load_valid && load_ready;
  assign last_pay = (state == ST_PAY) && (cnt == PAY_LAST);
  assign sr_shift = ((state == ST_PRE) && (cnt == PRE_LAST))
                  || (state == ST_PAY);

  seq_shift_out #(
    .W (DATA_W)
  ) u_shift (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .shift (sr_shift),
    .din   (load_data),
    .msb   (sr_msb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      pre_sr     <= '0;
      data_out   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      load_ready <= 1'b1;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            state      <= ST_PRE;
            cnt        <= '0;
            pre_sr     <= PREAMBLE << 1;
            data_out   <= PREAMBLE[PRE_LEN-1];
            busy       <= 1'b1;
            load_ready <= 1'b0;
          end
        end
        ST_PRE, ST_PAY: begin
          // Abort and normal end of payload share the exit path.
          if (abort || last_pay) begin
            state      <= HAS_GAP ? ST_GAP : ST_IDLE;
            cnt        <= '0;
            data_out   <= 1'b0;
            busy       <= HAS_GAP;
            load_ready <= !HAS_GAP;
          end else if (state == ST_PRE) begin
            if (cnt == PRE_LAST) begin
              state      <= ST_PAY;
              cnt        <= '0;
              data_out   <= sr_msb;
              frame_done <= ONE_BIT;
            end else begin
              cnt      <= cnt + 1'b1;
              data_out <= pre_sr[PRE_LEN-1];
              pre_sr   <= pre_sr << 1;
            end
          end else begin
            cnt        <= cnt + 1'b1;
            data_out   <= sr_msb;
            frame_done <= (cnt == PAY_PEN);
          end
        end
        ST_GAP: begin
          if (cnt == GAP_LAST) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            busy       <= 1'b0;
            load_ready <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sequence_tx.sv
// Self-checking bench for sequence_tx: frame table plus scoreboard queue.
// Expected streams come from a cycle-indexed frame model.
module tb_sequence_tx;

  logic       clk;
  logic       rst;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_ready;
  logic       abort;
  logic       data_out;
  logic       busy;
  logic       frame_done;

  sequence_tx dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .abort      (abort),
    .data_out   (data_out),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         ab;
    int         bp;
    bit         det;
  } vec_t;

  typedef struct {
    int         c;
    logic [3:0] v;
  } exp_t;

  exp_t q[$];
  vec_t tab[8];
  int   nvec;
  int   nerr;

  logic [3:0] hist;
  logic       fire;
  logic [3:0] outs;

  // Reference 1010 detector fed from the serial line.
  always @(posedge clk) begin
    if (rst) hist <= 4'b0;
    else     hist <= {hist[2:0], data_out};
  end

  assign fire = (hist == 4'b1010);
  assign outs = {data_out, frame_done, busy, load_ready};

  function automatic logic [3:0] model(input logic [7:0] d,
                                       input int ab, input int c);
    logic [3:0] pre;
    logic       b;
    bit         eff;
    int         fin;
    pre = 4'b1010;
    eff = (ab >= 1) && (ab <= 12);
    fin = eff ? ab : 12;
    if (c <= fin) begin
      if (c <= 4) b = pre[2'(4 - c)];
      else        b = d[3'(12 - c)];
      return {b, (!eff && c == 12), 1'b1, 1'b0};
    end
    if (c <= fin + 2) return 4'b0010;
    return 4'b0001;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int c,
                     input logic [3:0] act, input logic [3:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s cycle %0d: got %b want %b",
               nm, c, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    exp_t e;
    int   fin;
    load_data  = v.data;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    fin = (v.ab >= 1 && v.ab <= 12) ? v.ab : 12;
    for (int k = 1; k <= fin + 3; k++)
      q.push_back('{k, model(v.data, v.ab, k)});
    while (q.size() > 0) begin
      e = q.pop_front();
      chk(nm, e.c, outs, e.v);
      if (v.det)
        chk("detect", e.c, {3'b0, fire}, {3'b0, e.c == 5});
      abort      = (e.c == v.ab);
      load_valid = (e.c == v.bp);
      if (e.c == v.bp) load_data = 8'h3C;
      if (q.size() > 0) tick();
    end
    abort      = 1'b0;
    load_valid = 1'b0;
  endtask

  initial begin
    clk        = 1'b0;
    rst        = 1'b1;
    load_valid = 1'b0;
    load_data  = 8'h00;
    abort      = 1'b0;
    nvec       = 0;
    nerr       = 0;

    tab[0] = '{8'hA5, 0, 0, 1'b0};
    tab[1] = '{8'hFF, 0, 0, 1'b0};
    tab[2] = '{8'h00, 0, 0, 1'b1};
    tab[3] = '{8'h5A, 0, 6, 1'b0};
    tab[4] = '{8'hC3, 8, 0, 1'b0};
    tab[5] = '{8'h96, 13, 14, 1'b0};
    tab[6] = '{8'h69, 2, 0, 1'b0};
    tab[7] = '{8'h0F, 11, 0, 1'b0};

    repeat (3) begin
      tick();
      chk("reset", 0, outs, 4'b0001);
    end
    rst = 1'b0;
    tick();
    chk("idle", 0, outs, 4'b0001);

    for (int i = 0; i < 8; i++)
      run_vec(tab[i], $sformatf("frame%0d", i));

    load_data  = 8'hE7;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    tick();
    tick();
    chk("rst_pre2", 3, outs, 4'b1010);
    rst        = 1'b1;
    load_valid = 1'b1;
    abort      = 1'b1;
    tick();
    chk("rst_mid", 0, outs, 4'b0001);
    rst        = 1'b0;
    load_valid = 1'b0;
    abort      = 1'b0;
    tick();
    chk("rst_after", 0, outs, 4'b0001);

    run_vec('{8'h81, 0, 0, 1'b0}, "post_rst");

    abort = 1'b1;
    tick();
    chk("idle_abort", 0, outs, 4'b0001);
    tick();
    chk("idle_abort", 0, outs, 4'b0001);
    abort = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
